// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS MEM stage: opcodes, access size, FSM states,
// and opcode decode helpers.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;
    typedef enum logic {IDLE, WAIT} state_e;

    // Unknown opcodes that still touch memory fall back to a word access.
    function automatic size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return BYTE;
            OP_LH, OP_LHU, OP_SH: return HALF;
            default:              return WORD;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output req, we, addr, be, wdata, err, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, err, output rdata, ack);
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: byte enables and store replication on the way out,
// lane extraction plus sign/zero extension on the way back. Purely combinational.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_signed,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);
    logic [7:0]  w_bytes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_bytes[gi] = i_load_word[gi*8 +: 8];
        end
    endgenerate

    assign w_byte = w_bytes[i_lane];
    assign w_half = i_lane[1] ? i_load_word[31:16] : i_load_word[15:0];

    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_load_word;
        case (i_size)
            BYTE: begin
                o_be        = 4'b0001 << i_lane;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            HALF: begin
                o_be        = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: drives the data-memory port, stalls for slow memory with a timeout
// abort, and registers MEM/WB. Define MEM_ALIGN_CHECK_EN to suppress misaligned accesses.
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_alu_result,
    input  logic [31:0] EX_MEM_B_value,
    input  logic [4:0]  EX_MEM_dst_reg,
    input  logic [5:0]  EX_MEM_opcode,
    input  logic        EX_MEM_mem_read,
    input  logic        EX_MEM_mem_write,
    input  logic        EX_MEM_wb_reg_write,
    input  logic        EX_MEM_wb_mem_to_reg,
    output logic [31:0] mem_fwd_val,
    output logic        mem_stall,
    mem_stage_if.master dmem,
    output logic [31:0] MEM_WB_read_data,
    output logic [31:0] MEM_WB_alu_result,
    output logic [4:0]  MEM_WB_dst_reg,
    output logic        MEM_WB_wb_reg_write,
    output logic        MEM_WB_wb_mem_to_reg
);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

    state_e          r_state;
    logic [TO_W-1:0] r_cnt;
    logic [31:0]     r_read_data;
    logic [31:0]     r_alu_result;
    logic [4:0]      r_dst_reg;
    logic            r_reg_write;
    logic            r_mem_to_reg;

    logic        w_access;
    size_e       w_size;
    logic        w_misalign;
    logic        w_align_err;
    logic        w_timeout;
    logic        w_stall;
    logic [31:0] w_load_data;

    assign w_access = EX_MEM_mem_read | EX_MEM_mem_write;
    assign w_size   = op_size(EX_MEM_opcode);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((w_size == HALF) & EX_MEM_alu_result[0]) |
                        ((w_size == WORD) & (EX_MEM_alu_result[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    mem_lane_align u_lane (
        .i_size       (w_size),
        .i_lane       (EX_MEM_alu_result[1:0]),
        .i_signed     (op_signed(EX_MEM_opcode)),
        .i_store_data (EX_MEM_B_value),
        .i_load_word  (dmem.rdata),
        .o_be         (dmem.be),
        .o_wdata      (dmem.wdata),
        .o_load_data  (w_load_data)
    );

    // A misaligned access can only be seen in IDLE: WAIT is entered for aligned ones only.
    assign w_align_err = (r_state == IDLE) & w_access & w_misalign;
    assign w_timeout   = (r_state == WAIT) & ~dmem.ack & (r_cnt == TO_LIM);
    assign w_stall     = (r_state == IDLE) ? (w_access & ~w_misalign & ~dmem.ack)
                                           : (~dmem.ack & ~w_timeout);

    assign mem_fwd_val = EX_MEM_alu_result;
    assign mem_stall   = w_stall;
    assign dmem.req    = (r_state == WAIT) | (w_access & ~w_misalign);
    assign dmem.we     = EX_MEM_mem_write;
    assign dmem.addr   = {EX_MEM_alu_result[31:2], 2'b00};
    assign dmem.err    = ~rst & (w_timeout | w_align_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_dst_reg    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access & ~w_misalign & ~dmem.ack) begin
                        r_state <= WAIT;
                        r_cnt   <= TO_W'(1);
                    end
                end
                WAIT: begin
                    if (dmem.ack | w_timeout) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Stalled cycles insert a bubble; data fields keep their last value.
            if (w_stall) begin
                r_reg_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
            end else begin
                r_alu_result <= EX_MEM_alu_result;
                r_dst_reg    <= EX_MEM_dst_reg;
                r_reg_write  <= EX_MEM_wb_reg_write & ~w_align_err;
                r_mem_to_reg <= EX_MEM_wb_mem_to_reg;
                r_read_data  <= (w_timeout | w_align_err) ? 32'h0 : w_load_data;
            end
        end
    end

    assign MEM_WB_read_data     = r_read_data;
    assign MEM_WB_alu_result    = r_alu_result;
    assign MEM_WB_dst_reg       = r_dst_reg;
    assign MEM_WB_wb_reg_write  = r_reg_write;
    assign MEM_WB_wb_mem_to_reg = r_mem_to_reg;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline MEM stage. Consumes the EX/MEM pipeline register and drives a req/ack data-memory port.
- Performs byte/halfword/word loads and stores: lane select, store replication, load sign/zero extension.
- Registers the MEM/WB pipeline register.
- Produces the MEM forwarding value and a pipeline stall for multi-cycle memory.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without ack before the access is aborted (1..65535).
- TO_W, 16: timeout counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- EX_MEM_alu_result  in  32  effective address / ALU result
- EX_MEM_B_value  in  32  store data
- EX_MEM_dst_reg  in  5  destination register
- EX_MEM_opcode  in  6  instruction opcode
- EX_MEM_mem_read  in  1  load
- EX_MEM_mem_write  in  1  store
- EX_MEM_wb_reg_write  in  1  WB control
- EX_MEM_wb_mem_to_reg  in  1  WB control
- mem_fwd_val  out  32  forwarding value = EX_MEM_alu_result (combinational)
- mem_stall  out  1  freeze IF..EX and the EX/MEM register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address {EX_MEM_alu_result[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  access complete
- dmem_err  out  1  one-cycle pulse on timeout abort
- MEM_WB_read_data  out  32  extended load data
- MEM_WB_alu_result  out  32  registered alu result
- MEM_WB_dst_reg  out  5
- MEM_WB_wb_reg_write  out  1
- MEM_WB_wb_mem_to_reg  out  1

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all registered outputs are 0, the FSM goes to IDLE, and the timeout counter is 0.
- Byte order: little-endian. The byte lane is EX_MEM_alu_result[1:0].
- Opcodes:
  - LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25: loads.
  - SB 0x28, SH 0x29, SW 0x2B: stores.
  - Any other opcode with mem_read or mem_write set is treated as a word access.
- Byte enables:
  - Byte access: be = 1 << a[1:0].
  - Half access: be = a[1] ? 4'b1100 : 4'b0011; a[0] is ignored.
  - Word access: be = 4'b1111.
- Store data: wdata = byte replicated x4, half replicated x2, or word.
- Load data: select the lane, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- access = EX_MEM_mem_read | EX_MEM_mem_write. Both set at once counts as a write.
- FSM, IDLE:
  - dmem_req = access (combinational); addr, be, we and wdata come from EX_MEM.
  - access & dmem_ack: zero-wait. Stay in IDLE, no stall, MEM_WB loads at the next edge.
  - access & ~dmem_ack: go to WAIT. mem_stall = 1 in this cycle.
- FSM, WAIT:
  - dmem_req stays 1; addr, be, we and wdata stay stable (EX_MEM is frozen by the stall).
  - mem_stall = ~dmem_ack.
  - On ack: MEM_WB loads, return to IDLE, counter cleared.
  - Counter increments each cycle without ack. When it reaches TIMEOUT_CYCLES:
    - req drops next cycle and the FSM goes to IDLE;
    - MEM_WB loads with read_data = 0;
    - dmem_err = 1 for that cycle;
    - mem_stall = 0 in that cycle.
- MEM_WB update: every non-stalled cycle MEM_WB loads EX_MEM (alu_result, dst_reg, controls, extended data).
- Stalled cycles: MEM_WB loads a bubble (wb_reg_write = 0, wb_mem_to_reg = 0); data fields hold.
- Non-memory instructions pass through with 1-cycle latency and never stall.
- Reset during WAIT: the FSM goes to IDLE and req is 0 from the next cycle. No MEM_WB load, no err pulse.
- ack in IDLE with no access is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a misaligned access is suppressed.
  - Misaligned means a half access with a[0]=1, or a word access with a[1:0]!=0.
  - Suppression: dmem_req = 0, no stall, dmem_err pulses for 1 cycle, MEM_WB loads with wb_reg_write forced to 0.
- Undefined: low address bits are ignored as described above, and no alignment error is raised.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the opcode constants;
  - the size enum (BYTE, HALF, WORD);
  - the FSM state enum (IDLE, WAIT).
- One sub-module, mem_lane_align: combinational be/wdata generation and load extraction/extension. It is reusable by the instruction-fetch side.

Test Plan:
- SW at 0x100 of 0xDEADBEEF, ack same cycle -> req=1, be=1111, wdata=0xDEADBEEF, mem_stall never 1.
- SB of 0x000000A5 at 0x103 -> be=1000, wdata=0xA5A5A5A5. LB from 0x103 with rdata=0x80000000 -> MEM_WB_read_data=0xFFFFFF80. LBU with the same rdata -> 0x00000080.
- LH at 0x102 with rdata=0x8001_1234 and ack after 3 wait cycles -> mem_stall=1 for 3 cycles, 3 bubbles with reg_write=0, then read_data=0xFFFF8001 with dst/reg_write from EX_MEM.
- LW with no ack and TIMEOUT_CYCLES=4 -> stall for 4 cycles, then dmem_err 1 cycle, read_data=0, req drops, FSM in IDLE.
- rst asserted during WAIT -> next cycle req=0, all MEM_WB outputs 0, no err. ADD (no access) -> 1-cycle pass-through, mem_fwd_val=alu_result.
- With MEM_ALIGN_CHECK_EN, LW at 0x101 -> no req, dmem_err 1 cycle, MEM_WB_wb_reg_write=0.
